// File: rtl/piso_tx_pkg.sv
// Shared definitions for the serial link blocks (piso_tx and the planned sipo_rx).
package piso_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } piso_state_e;

    localparam int unsigned MIN_WIDTH = 2;
    localparam int unsigned MAX_WIDTH = 32;

    function automatic int unsigned countWidth(input int unsigned width);
        return (width < MIN_WIDTH) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Mod-WIDTH bit position counter; tc flags the final bit position of a frame.
module piso_bit_counter
    import piso_tx_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CW = countWidth(WIDTH);
    localparam logic [CW-1:0] LAST_POS = CW'(WIDTH - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == LAST_POS) ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == LAST_POS);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: captures a word on load && ready, then
// shifts it out on q one bit per clock, with back-to-back reload on the last bit.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             q,
    output logic             busy,
    output logic             last
);

    piso_state_e      state_q;
    piso_state_e      state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             q_q;
    logic             q_d;
    logic             tc;
    logic             accept;
    logic             cntClr;
    logic             cntEn;

    assign busy   = (state_q == ST_SHIFT);
    assign last   = busy && tc;
    assign ready  = !busy || last;
    assign accept = load && ready;
    assign q      = q_q;

    // Counter restarts on every accepted word and when a frame finishes
    assign cntClr = accept || last;
    assign cntEn  = busy && !tc;

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cntClr),
        .en_i  (cntEn),
        .tc_o  (tc)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        q_d     = q_q;
        if (accept) begin
            state_d = ST_SHIFT;
            // The first bit goes straight to q; the shift register keeps the rest
            if (MSB_FIRST) begin
                q_d     = din[WIDTH-1];
                shreg_d = din << 1;
            end else begin
                q_d     = din[0];
                shreg_d = din >> 1;
            end
        end else if (last) begin
            state_d = ST_IDLE;
            q_d     = 1'b0;
            shreg_d = '0;
        end else if (busy) begin
            if (MSB_FIRST) begin
                q_d     = shreg_q[WIDTH-1];
                shreg_d = shreg_q << 1;
            end else begin
                q_d     = shreg_q[0];
                shreg_d = shreg_q >> 1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            q_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            q_q     <= q_d;
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: a scoreboard of expected serial bits drives all checks,
// with a 4-stage siso loopback on the WIDTH=4 instance.
module tb_piso_tx;

    typedef struct {
        logic q;
        logic last;
    } expBit_t;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic       load;
    logic       ready;
    logic       q;
    logic       busy;
    logic       last;

    logic [7:0] din8;
    logic       load8;
    logic       ready8;
    logic       q8;
    logic       busy8;
    logic       last8;

    logic [3:0] siso;
    logic [3:0] expHist;
    expBit_t    expQ[$];
    int         testsRun;
    int         testsFailed;

    piso_tx #(
        .WIDTH     (4),
        .MSB_FIRST (1'b1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .load  (load),
        .ready (ready),
        .q     (q),
        .busy  (busy),
        .last  (last)
    );

    piso_tx #(
        .WIDTH     (8),
        .MSB_FIRST (1'b0)
    ) dut8 (
        .clk   (clk),
        .rst   (rst),
        .din   (din8),
        .load  (load8),
        .ready (ready8),
        .q     (q8),
        .busy  (busy8),
        .last  (last8)
    );

    // Downstream 4-stage siso receiving the serial line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            siso <= '0;
        end else begin
            siso <= {siso[2:0], q};
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0b expected=%0b at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic pushFrame(input logic [3:0] word);
        expBit_t e;
        for (int k = 0; k < 4; k++) begin
            e.q    = word[3-k];
            e.last = (k == 3);
            expQ.push_back(e);
        end
    endtask

    // Compare this cycle's outputs with the head of the scoreboard (or idle values)
    task automatic checkCycle();
        logic expq;
        logic expLast;
        logic expBusy;
        logic expReady;
        if (expQ.size() > 0) begin
            expq     = expQ[0].q;
            expLast  = expQ[0].last;
            expBusy  = 1'b1;
            expReady = expQ[0].last;
        end else begin
            expq     = 1'b0;
            expLast  = 1'b0;
            expBusy  = 1'b0;
            expReady = 1'b1;
        end
        checkOutput("q", q, expq);
        checkOutput("busy", busy, expBusy);
        checkOutput("last", last, expLast);
        checkOutput("ready", ready, expReady);
        checkOutput("sisoLoop", siso[3], expHist[3]);
        expHist = {expHist[2:0], expq};
    endtask

    // Drive one cycle of load/din, advance the scoreboard across the edge, then check
    task automatic applyStimulus(input logic ld, input logic [3:0] word);
        logic willAccept;
        load = ld;
        din  = word;
        willAccept = ld && ((expQ.size() == 0) || expQ[0].last);
        @(posedge clk);
        if (expQ.size() > 0) expQ.delete(0);
        if (willAccept) pushFrame(word);
        #1;
        checkCycle();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_q"}, q, 1'b0);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_last"}, last, 1'b0);
        checkOutput({tag, "_ready"}, ready, 1'b1);
    endtask

    initial begin
        logic [7:0] word8;
        logic [7:0] words8[2];
        testsRun    = 0;
        testsFailed = 0;
        expHist     = '0;
        rst   = 1'b1;
        load  = 1'b1;
        din   = 4'hF;
        load8 = 1'b0;
        din8  = '0;

        // Reset with load asserted: nothing may be captured
        #1;
        checkResetOutputs("reset");
        #1;
        rst  = 1'b0;
        load = 1'b0;
        applyStimulus(1'b0, 4'h0);

        // Single frame MSB first
        applyStimulus(1'b1, 4'b1011);
        applyStimulus(1'b0, 4'h0);
        applyStimulus(1'b0, 4'h0);
        applyStimulus(1'b0, 4'h0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'h0);

        // Back-to-back frames with load held high
        applyStimulus(1'b1, 4'b1100);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'b0011);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'h0);

        // Load pulse mid-frame must be ignored
        applyStimulus(1'b1, 4'b0110);
        applyStimulus(1'b0, 4'h0);
        applyStimulus(1'b1, 4'hF);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'h0);

        // Reset mid-frame at count==2
        applyStimulus(1'b1, 4'b1011);
        applyStimulus(1'b0, 4'h0);
        applyStimulus(1'b0, 4'h0);
        #2;
        rst  = 1'b1;
        load = 1'b1;
        din  = 4'hF;
        #1;
        checkResetOutputs("midReset");
        @(posedge clk);
        #1;
        checkResetOutputs("midResetHeld");
        checkOutput("midResetSiso", siso[3], 1'b0);
        rst  = 1'b0;
        load = 1'b0;
        expQ.delete();
        expHist = '0;
        applyStimulus(1'b1, 4'b1000);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 4'h0);

        // WIDTH=8, LSB first
        words8[0] = 8'h01;
        words8[1] = 8'hA6;
        for (int w = 0; w < 2; w++) begin
            word8 = words8[w];
            load8 = 1'b1;
            din8  = word8;
            @(posedge clk);
            #1;
            load8 = 1'b0;
            din8  = 8'hFF;
            for (int k = 0; k < 8; k++) begin
                checkOutput("q8", q8, word8[k]);
                checkOutput("busy8", busy8, 1'b1);
                checkOutput("last8", last8, (k == 7));
                checkOutput("ready8", ready8, (k == 7));
                @(posedge clk);
                #1;
            end
            checkOutput("q8Idle", q8, 1'b0);
            checkOutput("busy8Idle", busy8, 1'b0);
            checkOutput("ready8Idle", ready8, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
